// File: rtl/seg7_text_scroller.sv
// Purpose: N-digit 7-seg text engine (fixed, status, pass-through, scrolling message) with a multiplexed segment/digit bus.
// Latency: oChars 1 cycle after mode/data/buffer/offset change; oSeg/oDigitEn 1 cycle after the scan index moves.
// Backpressure: none, free-running display path; message writes are accepted every cycle.
//
// Ports: iClk/iRst_n clock and async active-low reset; iMode selects the text source;
//   iDataBus pass-through chars; iMsgWrEn/iMsgAddr/iMsgWrData message buffer write port;
//   iScrollStart/iLoop scroll control; iBlink blink request (only honoured with SEG7_BLINK_EN);
//   oChars per-digit codes; oSeg/oDigitEn multiplexed bus (active-low); oBusy/oScrollDone scroll status.
// Digit k sits in oChars[8*(NUM_DIGITS-1-k) +: 8], so digit 0 (leftmost) is the most significant byte
// and a concatenation {d0,d1,...} reads left to right like the display. iDataBus uses the same packing.
// Optional macro SEG7_BLINK_EN adds the blink counter; without it iBlink is ignored.
module seg7_text_scroller #(
  parameter int NUM_DIGITS = 4,
  parameter int MSG_LEN    = 16,
  parameter int SCROLL_DIV = 12500000,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 25000000,
  localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic                    iClk,
  input  logic                    iRst_n,
  input  logic [1:0]              iMode,
  input  logic [8*NUM_DIGITS-1:0] iDataBus,
  input  logic                    iMsgWrEn,
  input  logic [AW-1:0]           iMsgAddr,
  input  logic [7:0]              iMsgWrData,
  input  logic                    iScrollStart,
  input  logic                    iLoop,
  input  logic                    iBlink,
  output logic [8*NUM_DIGITS-1:0] oChars,
  output logic [7:0]              oSeg,
  output logic [NUM_DIGITS-1:0]   oDigitEn,
  output logic                    oBusy,
  output logic                    oScrollDone
);

  localparam logic [7:0] CH_ONE = 8'hF9, CH_THREE = 8'hB0, CH_SEVEN = 8'hF8;
  localparam logic [7:0] CH_S = 8'h92, CH_R = 8'hCE, CH_T = 8'h87, CH_BLANK = 8'hFF;

  localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int OW = $clog2(MSG_LEN + NUM_DIGITS);
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [SW-1:0] STEP_LAST = SW'(SCROLL_DIV - 1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [OW-1:0] OFF_LAST  = OW'(MSG_LEN + NUM_DIGITS - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_SCROLL = 1'b1} state_t;

  state_t          state_q, state_nxt;
  logic [SW-1:0]   step_cnt;
  logic [OW-1:0]   offset;
  logic [CW-1:0]   scan_cnt;
  logic [IW-1:0]   scan_idx;
  logic [7:0]      msg [MSG_LEN];

  logic mode_scroll, start_req, abort_req, step_wrap, last_step, done_nxt;

  // ---------------- scroll FSM ----------------
  assign mode_scroll = (iMode == 2'd3);
  assign start_req   = mode_scroll && iScrollStart;
  assign abort_req   = (state_q == ST_SCROLL) && !mode_scroll;
  assign step_wrap   = (state_q == ST_SCROLL) && (step_cnt == STEP_LAST);
  // The step that would take offset to MSG_LEN+NUM_DIGITS ends the pass.
  assign last_step   = step_wrap && (offset == OFF_LAST);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state_q <= ST_IDLE;
    else         state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    done_nxt  = 1'b0;
    case (state_q)
      ST_IDLE:   if (start_req) state_nxt = ST_SCROLL;
      ST_SCROLL: begin
        if (abort_req)               state_nxt = ST_IDLE;
        else if (start_req)          state_nxt = ST_SCROLL;
        else if (last_step && !iLoop) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    oBusy = (state_q == ST_SCROLL);
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      step_cnt    <= '0;
      offset      <= '0;
      oScrollDone <= 1'b0;
    end else begin
      oScrollDone <= done_nxt;
      if (abort_req || start_req || state_q == ST_IDLE) begin
        step_cnt <= '0;
        offset   <= '0;
      end else if (step_wrap) begin
        step_cnt <= '0;
        offset   <= last_step ? '0 : offset + 1'b1;
      end else begin
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end

  // ---------------- message buffer ----------------
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int m = 0; m < MSG_LEN; m++) msg[m] <= CH_BLANK;
    end else if (iMsgWrEn && (int'(iMsgAddr) < MSG_LEN)) begin
      for (int m = 0; m < MSG_LEN; m++)
        if (int'(iMsgAddr) == m) msg[m] <= iMsgWrData;
    end
  end

  // ---------------- character selection ----------------
  logic [8*NUM_DIGITS-1:0] chars_nxt;

  always_comb begin
    logic [7:0] ch;
    int         j;
    chars_nxt = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      ch = CH_BLANK;
      j  = int'(offset) + k - NUM_DIGITS;
      case (iMode)
        2'd0: begin
          if (k == 0)                ch = CH_ONE;
          else if (k == 1 || k == 2) ch = CH_THREE;
          else if (k == 3)           ch = CH_SEVEN;
        end
        2'd1: begin
          if (k == 0)      ch = CH_R;
          else if (k == 1) ch = CH_S;
          else if (k == 2) ch = CH_T;
        end
        2'd2:    ch = iDataBus[8*(NUM_DIGITS-1-k) +: 8];
        default: begin
          // Negative j means the message has not reached this digit yet.
          for (int m = 0; m < MSG_LEN; m++)
            if (m == j) ch = msg[m];
        end
      endcase
      chars_nxt[8*(NUM_DIGITS-1-k) +: 8] = ch;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) oChars <= '1;
    else         oChars <= chars_nxt;
  end

  // ---------------- blink ----------------
  logic blank_out;
`ifdef SEG7_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  // Counter and phase are held at zero while no blink is requested, so each
  // request starts with a full visible half-period.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!iBlink) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end
  assign blank_out = iBlink && blink_phase;
`else
  logic unused_blink;
  assign unused_blink = iBlink | (BLINK_DIV < 1);
  assign blank_out    = 1'b0;
`endif

  // ---------------- scan multiplexer ----------------
  logic [7:0] seg_nxt;

  always_comb begin
    seg_nxt = CH_BLANK;
    for (int m = 0; m < NUM_DIGITS; m++)
      if (scan_idx == IW'(m)) seg_nxt = oChars[8*(NUM_DIGITS-1-m) +: 8];
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      oSeg     <= CH_BLANK;
      oDigitEn <= '1;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      if (blank_out) begin
        oSeg     <= CH_BLANK;
        oDigitEn <= '1;
      end else begin
        oSeg     <= seg_nxt;
        oDigitEn <= ~(NUM_DIGITS'(1) << scan_idx);
      end
    end
  end

endmodule
